// File: rtl/z_core_pkg.sv
// -----------------------------------------------------------------------------
// z_core_pkg
// Shared types and constants for the Z-Core instruction-cache refill path.
//   refill_state_t : refill controller states (IDLE/REQ/WAIT_RSP/WRITE/DRAIN)
//   WORD_OFFSET    : number of byte-offset bits below an instruction word
// -----------------------------------------------------------------------------
package z_core_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    WRITE    = 3'd3,
    DRAIN    = 3'd4
  } refill_state_t;

  localparam int unsigned WORD_OFFSET = 2;

endpackage

// File: rtl/z_core_icache_refill.sv
// -----------------------------------------------------------------------------
// z_core_icache_refill
// Miss-refill controller for the Z-Core instruction cache. On a cache miss it
// stalls fetch, issues a single word read to memory, and writes the returned
// word into the cache through its synchronous write port.
//
// Optional feature macro: Z_CORE_REFILL_TIMEOUT_EN
//   When defined, a response that does not arrive within TIMEOUT_CYCLES cycles
//   of WAIT_RSP/DRAIN aborts the refill and pulses refill_err.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   fetch_addr      : address presented to the cache by the fetch stage
//   cache_miss      : combinational miss for fetch_addr
//   flush           : pipeline redirect, abandons the current refill
//   stall           : hold the fetch stage
//   cache_wen       : cache write strobe (one cycle per completed refill)
//   cache_addr      : cache write address (registered)
//   cache_wdata     : cache write data (registered)
//   mem_req_valid   : read request valid (held until mem_req_ready)
//   mem_req_ready   : memory accepts request
//   mem_req_addr    : word-aligned request address
//   mem_rsp_valid   : single-cycle read data valid
//   mem_rsp_data    : read data
//   refill_err      : one-cycle timeout pulse (0 when the feature is off)
// -----------------------------------------------------------------------------
module z_core_icache_refill
  import z_core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  cache_miss,
  input  logic                  flush,
  output logic                  stall,
  output logic                  cache_wen,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  refill_err
);

  // Clears the byte offset within an instruction word.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << WORD_OFFSET) - ADDR_WIDTH'(1));

  refill_state_t         state_reg, state_next;
  logic [ADDR_WIDTH-1:0] miss_addr_reg, miss_addr_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  // Remembers a flush seen while the request was still waiting for ready, so
  // the eventual response is drained instead of written.
  logic                  drop_reg, drop_next;
  logic                  timeout_hit;
  logic                  err_pulse;

`ifdef Z_CORE_REFILL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] timeout_cnt_reg;

  // Counts cycles spent in WAIT_RSP/DRAIN; any state change restarts it, which
  // covers both entry into WAIT_RSP and the WAIT_RSP -> DRAIN hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      timeout_cnt_reg <= '0;
    end else if (state_reg == WAIT_RSP || state_reg == DRAIN) begin
      timeout_cnt_reg <= timeout_cnt_reg + TMO_W'(1);
    end
  end

  assign timeout_hit = (timeout_cnt_reg == TMO_W'(TIMEOUT_CYCLES));
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      miss_addr_reg <= '0;
      data_reg      <= '0;
      drop_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      miss_addr_reg <= miss_addr_next;
      data_reg      <= data_next;
      drop_reg      <= drop_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    miss_addr_next = miss_addr_reg;
    data_next      = data_reg;
    drop_next      = drop_reg;
    stall          = 1'b1;
    mem_req_valid  = 1'b0;
    cache_wen      = 1'b0;
    err_pulse      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // Responses arriving here belong to nobody and are ignored.
        stall     = cache_miss;
        drop_next = 1'b0;
        if (cache_miss && !flush) begin
          miss_addr_next = fetch_addr & ALIGN_MASK;
          state_next     = REQ;
        end
      end

      REQ: begin
        mem_req_valid = 1'b1;
        if (flush) begin
          drop_next = 1'b1;
        end
        if (mem_req_ready) begin
          drop_next  = 1'b0;
          state_next = (drop_reg || flush) ? DRAIN : WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        // A response in the same cycle as flush is still good data.
        if (mem_rsp_valid) begin
          data_next  = mem_rsp_data;
          state_next = WRITE;
        end else if (timeout_hit) begin
          err_pulse  = 1'b1;
          state_next = IDLE;
        end else if (flush) begin
          state_next = DRAIN;
        end
      end

      WRITE: begin
        cache_wen  = 1'b1;
        state_next = IDLE;
      end

      DRAIN: begin
        // Swallow the single outstanding response before accepting a new miss.
        if (mem_rsp_valid) begin
          state_next = IDLE;
        end else if (timeout_hit) begin
          err_pulse  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cache_addr   = miss_addr_reg;
  assign cache_wdata  = data_reg;
  assign mem_req_addr = miss_addr_reg;
  assign refill_err   = err_pulse;

endmodule

// File: doc/z_core_icache_refill.md
# z_core_icache_refill

Miss-refill controller that fills the Z-Core instruction cache. It watches the cache's combinational miss indication for the current fetch address and stalls the core. It fetches the missing word from memory over a valid/ready request and valid response channel, then writes the word into the cache through the cache's synchronous write port. It sits between the fetch stage, the instruction cache and the memory/bus adapter.

## Interface
Parameters:
- ADDR_WIDTH, 32, fetch/memory address width
- DATA_WIDTH, 32, instruction word width
- TIMEOUT_CYCLES, 64, response wait limit; used only with Z_CORE_REFILL_TIMEOUT_EN

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- fetch_addr  in  ADDR_WIDTH  address currently presented to the cache
- cache_miss  in  1  combinational miss from the cache for fetch_addr
- flush  in  1  pipeline redirect; abandons the current refill
- stall  out  1  hold fetch stage
- cache_wen  out  1  cache write strobe
- cache_addr  out  ADDR_WIDTH  cache write address
- cache_wdata  out  DATA_WIDTH  cache write data
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  word-aligned request address
- mem_rsp_valid  in  1  read data valid (single-cycle pulse per request)
- mem_rsp_data  in  DATA_WIDTH  read data
- refill_err  out  1  one-cycle pulse on timeout; constant 0 without the macro

## Operation
- States: IDLE, REQ, WAIT_RSP, WRITE, DRAIN.
- IDLE: if cache_miss && !flush, latch fetch_addr with bits [1:0] cleared into miss_addr and go to REQ. mem_rsp_valid is ignored.
- REQ: mem_req_valid=1, mem_req_addr=miss_addr held stable. Once asserted, valid is never withdrawn before ready.
  - On ready, go to WAIT_RSP, or to DRAIN if flush was seen in REQ (sticky drop flag).
- WAIT_RSP: on mem_rsp_valid, capture mem_rsp_data and go to WRITE. On flush without rsp, go to DRAIN. If flush and rsp occur in the same cycle, the response wins and the state goes to WRITE.
- WRITE: cache_wen=1 for exactly one cycle, cache_addr=miss_addr, cache_wdata=captured data, then IDLE. flush in WRITE does not cancel the write, because the data is valid.
- DRAIN: discard the next mem_rsp_valid, then go to IDLE. Exactly one outstanding request exists at any time.
- stall = cache_miss in IDLE; 1 in REQ, WAIT_RSP, WRITE and DRAIN.
- cache_addr and cache_wdata are don't-care when cache_wen=0 and are driven from registers.

## Timing
- Reset (async, immediate) values: state=IDLE, stall follows cache_miss, cache_wen=0, mem_req_valid=0, refill_err=0, miss_addr=0, data=0, timeout counter=0.
- Miss seen in cycle 0 → mem_req_valid high in cycle 1.
- Request accepted in cycle a, mem_rsp_valid in cycle r≥a+1 → cache_wen in cycle r+1 → IDLE in r+2. In r+2, the cache hits combinationally and stall drops.
- Minimum miss penalty with ready=1 and rsp one cycle after accept: miss detected in cycle 0, write in cycle 3, stall low in cycle 4.
- Reset mid-refill drops all state. A response arriving after reset is ignored in IDLE.

## Configuration
- Z_CORE_REFILL_TIMEOUT_EN defined: a counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_RSP or DRAIN and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES without a response: refill_err=1 for one cycle, no cache write, go to IDLE.
  - If the miss persists, the next cycle retries.
- Undefined: no counter; WAIT_RSP and DRAIN wait indefinitely; refill_err tied 0.

## Structure
- z_core_pkg holds refill_state_t, the 5-value enum IDLE/REQ/WAIT_RSP/WRITE/DRAIN, and the word-offset constant (2).
- Single flat module with no sub-module; the timeout counter is inline under the macro.

## Test plan
- Miss at 0x0000_1000, ready=1, rsp 0xDEADBEEF two cycles later → mem_req_addr=0x1000 for one cycle; one cache_wen with addr 0x1000, data 0xDEADBEEF; stall low the cycle after.
- Unaligned fetch 0x0000_1406, ready held low 3 cycles → mem_req_valid and addr=0x1404 stay stable 4 cycles; the write lands at 0x1404.
- flush during WAIT_RSP, then rsp 0xCAFEBABE → no cache_wen; IDLE after the rsp; a new miss at 0x2000 refills normally.
- flush and mem_rsp_valid (0x12345678) in the same cycle → the write of 0x12345678 still occurs.
- rst asserted while in WAIT_RSP → outputs return to reset values immediately; a later stray rsp produces no cache_wen.
- With Z_CORE_REFILL_TIMEOUT_EN and TIMEOUT_CYCLES=8, no rsp → refill_err pulses once after 8 cycles in WAIT_RSP; no cache_wen; a retry request is issued.
